int_mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between the AXI read controller (RAddr*/RData/RResp) and the
//  AXI write controller (WAddr*/WData/WStrb/WResp). Grants one beat per cycle, with round-robin and

---
 rtl/int_mem_pkg.sv | 12 +
 rtl/int_mem_rr_grant.sv | 44 ++++
 rtl/int_mem_port_arbiter.sv | 68 ++++++
 tb/tb_int_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_mem_pkg.sv
// int_mem_pkg: owner/response encodings and a width helper shared by the memory port arbiter.
package int_mem_pkg;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_RD = 2'd1, OWN_WR = 2'd2} owner_t;
   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/int_mem_rr_grant.sv
// int_mem_rr_grant: round-robin read/write grant with burst stickiness of up to LOCK_BEATS beats.
module int_mem_rr_grant
   import int_mem_pkg::*;
#(
   parameter int LOCK_BEATS = 4
) (
   input  logic ACLK,
   input  logic ARESETn,
   input  logic rd_req,
   input  logic wr_req,
   output logic gnt_rd,
   output logic gnt_wr
);
   localparam int CW = clog2(LOCK_BEATS + 1);
   localparam logic [CW-1:0] LOCK = CW'(LOCK_BEATS);
   owner_t owner, owner_n, last_gnt, last_gnt_n;
   logic [CW-1:0] beat_cnt, beat_cnt_n;
   logic prefer_rd;
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         owner    <= OWN_NONE;
         last_gnt <= OWN_WR;
         beat_cnt <= '0;
      end else begin
         owner    <= owner_n;
         last_gnt <= last_gnt_n;
         beat_cnt <= beat_cnt_n;
      end
   always_comb begin
      owner_n    = gnt_rd ? OWN_RD : gnt_wr ? OWN_WR : OWN_NONE;
      last_gnt_n = owner_n == OWN_NONE ? last_gnt : owner_n;
      beat_cnt_n = owner_n == OWN_NONE ? '0 :
                   owner_n != owner    ? CW'(1) :
                   beat_cnt == LOCK    ? LOCK : beat_cnt + 1'b1;
   end
   // a sole requester always wins; the count just stays saturated
   always_comb begin
      prefer_rd = (owner == OWN_RD && beat_cnt < LOCK) ||
                  (owner == OWN_WR && beat_cnt == LOCK) ||
                  (owner == OWN_NONE && last_gnt == OWN_WR);
      gnt_rd    = rd_req & (~wr_req | prefer_rd);
      gnt_wr    = wr_req & ~gnt_rd;
   end
endmodule

// File: rtl/int_mem_port_arbiter.sv
// int_mem_port_arbiter: shares one single-port SRAM between AXI read and write beats, one beat per cycle,
// decoding the memory window and flagging out-of-range beats as errors without touching the SRAM.
module int_mem_port_arbiter
   import int_mem_pkg::*;
#(
   parameter int          DATA_WIDTH = 128,
   parameter int          MEM_AW     = 12,
   parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
   parameter int          LOCK_BEATS = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    RAddrValid,
   output logic                    RAddrReady,
   input  logic [31:0]             RAddrOut,
   output logic [DATA_WIDTH-1:0]   RData,
   output logic                    RResp,
   input  logic                    WAddrValid,
   output logic                    WAddrReady,
   input  logic [31:0]             WAddrOut,
   input  logic [DATA_WIDTH-1:0]   WData,
   input  logic [DATA_WIDTH/8-1:0] WStrb,
   output logic                    WResp,
   output logic                    MemCs,
   output logic                    MemWe,
   output logic [MEM_AW-1:0]       MemAddr,
   output logic [DATA_WIDTH-1:0]   MemWData,
   output logic [DATA_WIDTH/8-1:0] MemBe,
   input  logic [DATA_WIDTH-1:0]   MemRData
);
   localparam int LSB = clog2(DATA_WIDTH / 8);
   localparam int HI  = MEM_AW + LSB;
   logic gnt_rd, gnt_wr, in_range, rd_ok;
   logic [31:LSB] addr;
   logic unused_lsb;
   int_mem_rr_grant #(.LOCK_BEATS(LOCK_BEATS)) u_grant (
      .ACLK   (ACLK),
      .ARESETn(ARESETn),
      .rd_req (RAddrValid),
      .wr_req (WAddrValid),
      .gnt_rd (gnt_rd),
      .gnt_wr (gnt_wr)
   );
   assign unused_lsb = ^{RAddrOut[LSB-1:0], WAddrOut[LSB-1:0]};
   always_comb begin
      addr       = gnt_wr ? WAddrOut[31:LSB] : RAddrOut[31:LSB];
      in_range   = addr[31:HI] == MEM_BASE[31:HI];
      RAddrReady = gnt_rd;
      WAddrReady = gnt_wr;
      MemCs      = (gnt_rd | gnt_wr) & in_range;
      MemWe      = gnt_wr & in_range;
      MemAddr    = MemCs ? addr[HI-1:LSB] : '0;
      MemWData   = WData;
      MemBe      = MemWe ? WStrb : '0;
      RData      = rd_ok ? MemRData : '0;
   end
   // responses only refresh on their own handshake and otherwise hold
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         rd_ok <= 1'b0;
         RResp <= RESP_OK;
         WResp <= RESP_OK;
      end else begin
         rd_ok <= gnt_rd & in_range;
         if (gnt_rd) RResp <= in_range ? RESP_OK : RESP_ERR;
         if (gnt_wr) WResp <= in_range ? RESP_OK : RESP_ERR;
      end
endmodule

// File: tb/tb_int_mem_port_arbiter.sv
// tb_int_mem_port_arbiter: randomized bench with an SRAM model and a grant/data reference model.
module tb_int_mem_port_arbiter;
   localparam int DW = 128;
   localparam int BW = 16;
   localparam int LOCK = 4;
   logic ACLK = 1'b0, ARESETn = 1'b0;
   logic RAddrValid = 1'b0, WAddrValid = 1'b0;
   logic RAddrReady, WAddrReady, RResp, WResp, MemCs, MemWe;
   logic [31:0] RAddrOut = '0, WAddrOut = '0;
   logic [DW-1:0] WData = '0, RData, MemWData, MemRData;
   logic [BW-1:0] WStrb = '0, MemBe;
   logic [11:0] MemAddr;
   int n_cmp = 0, n_err = 0;
   logic [DW-1:0] sram [4096];
   logic [DW-1:0] ref_mem [4096];
   int last_side, prev_g, run, g_exp;
   logic exp_rresp, exp_wresp, exp_cs;
   logic [DW-1:0] exp_rdata;
   logic [11:0] exp_word;

   int_mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_AW(12), .MEM_BASE(32'h0), .LOCK_BEATS(LOCK)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .RAddrValid(RAddrValid), .RAddrReady(RAddrReady), .RAddrOut(RAddrOut), .RData(RData), .RResp(RResp),
      .WAddrValid(WAddrValid), .WAddrReady(WAddrReady), .WAddrOut(WAddrOut), .WData(WData), .WStrb(WStrb),
      .WResp(WResp), .MemCs(MemCs), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe),
      .MemRData(MemRData)
   );

   always #5 ACLK = ~ACLK;

   // write-first single-port SRAM; garbage on the read bus when not reading
   always @(posedge ACLK) begin
      if (MemCs && MemWe)
         for (int b = 0; b < BW; b++)
            if (MemBe[b]) sram[MemAddr][b*8 +: 8] <= MemWData[b*8 +: 8];
      MemRData <= (MemCs && !MemWe) ? sram[MemAddr] : {$urandom, $urandom, $urandom, $urandom};
   end

   function automatic logic [DW-1:0] init_word(int i);
      logic [31:0] v;
      v = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
      return {4{v}};
   endfunction

   function automatic int pick(logic rv, logic wv);
      if (rv && !wv) return 1;
      if (wv && !rv) return 2;
      if (!rv) return 0;
      if (prev_g == 0) return last_side == 2 ? 1 : 2;
      if (run >= LOCK) return 3 - prev_g;
      return prev_g;
   endfunction

   task automatic model_reset();
      last_side = 2;
      prev_g = 0;
      run = 0;
      exp_rresp = 1'b0;
      exp_wresp = 1'b0;
      exp_rdata = '0;
   endtask

   task automatic commit(int g, logic [31:0] ra, logic [31:0] wa, logic [DW-1:0] wd, logic [BW-1:0] ws);
      logic [31:0] a;
      logic inr;
      int w;
      a = g == 2 ? wa : ra;
      inr = a < 32'h0001_0000;
      w = int'((a / 16) % 4096);
      exp_cs = g != 0 && inr;
      exp_word = 12'(w);
      exp_rdata = '0;
      if (g == 1) begin
         exp_rresp = !inr;
         if (inr) exp_rdata = ref_mem[w];
      end
      if (g == 2) begin
         exp_wresp = !inr;
         if (inr)
            for (int b = 0; b < BW; b++)
               if (ws[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
      end
      run = g == 0 ? 0 : g == prev_g ? run + 1 : 1;
      if (g != 0) last_side = g;
      prev_g = g;
   endtask

   task automatic drive(logic rv, logic [31:0] ra, logic wv, logic [31:0] wa, logic [DW-1:0] wd, logic [BW-1:0] ws);
      @(negedge ACLK);
      RAddrValid = rv;
      RAddrOut = ra;
      WAddrValid = wv;
      WAddrOut = wa;
      WData = wd;
      WStrb = ws;
      #1;
      g_exp = pick(rv, wv);
      commit(g_exp, ra, wa, wd, ws);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge ACLK);
      ARESETn = 1'b0;
      RAddrValid = 1'b0;
      WAddrValid = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      model_reset();
   endtask

   function automatic logic [31:0] rand_in(int words);
      return {16'h0, 12'($urandom_range(0, words - 1)), 4'($urandom)};
   endfunction

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge ACLK);
      #1;
      n_cmp++;
      if ({RAddrReady, WAddrReady, MemCs, MemWe, MemAddr, MemBe} !== '0) begin
         n_err++;
         $display("FAIL reset_idle_outputs: got %h want 0", {RAddrReady, WAddrReady, MemCs, MemWe, MemAddr, MemBe});
      end
      n_cmp++;
      if ({RResp, WResp} !== 2'b00 || RData !== '0) begin
         n_err++;
         $display("FAIL reset_resp: got resp %b rdata %h want 00 and 0", {RResp, WResp}, RData);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      model_reset();
   endtask

   task automatic test_single_read();
      drive(1'b1, 32'h40, 1'b0, 32'h0, '0, '0);
      n_cmp++;
      if ({RAddrReady, WAddrReady, MemCs, MemWe, MemAddr} !== {4'b1010, 12'd4}) begin
         n_err++;
         $display("FAIL single_read_req: got rdy %b%b cs %b we %b addr %0d want 1 0 1 0 4", RAddrReady, WAddrReady, MemCs, MemWe, MemAddr);
      end
      tick();
      n_cmp++;
      if (RData !== init_word(4) || RResp !== 1'b0) begin
         n_err++;
         $display("FAIL single_read_data: got %h resp %b want %h resp 0", RData, RResp, init_word(4));
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
      n_cmp++;
      if (RData !== '0) begin
         n_err++;
         $display("FAIL idle_rdata_zero: got %h want 0", RData);
      end
   endtask

   task automatic test_contended();
      do_reset();
      for (int i = 0; i < 24; i++) begin
         drive(1'b1, rand_in(4096), 1'b1, rand_in(4096), rand_data(), 16'($urandom));
         n_cmp++;
         if (RAddrReady !== ((i / 4) % 2 == 0) || WAddrReady !== ((i / 4) % 2 == 1)) begin
            n_err++;
            $display("FAIL contended_pattern beat %0d: got rd %b wr %b want rd %b", i, RAddrReady, WAddrReady, (i / 4) % 2 == 0);
         end
         tick();
         n_cmp++;
         if (RData !== exp_rdata || RResp !== exp_rresp || WResp !== exp_wresp) begin
            n_err++;
            $display("FAIL contended_resp beat %0d: got %h %b %b want %h %b %b", i, RData, RResp, WResp, exp_rdata, exp_rresp, exp_wresp);
         end
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
   endtask

   task automatic test_write_stream();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 32'h0, 1'b1, rand_in(4096), rand_data(), 16'($urandom));
         n_cmp++;
         if ({RAddrReady, WAddrReady} !== 2'b01) begin
            n_err++;
            $display("FAIL wstream_grant beat %0d: got rd %b wr %b want 0 1", i, RAddrReady, WAddrReady);
         end
         tick();
         n_cmp++;
         if (dut.u_grant.beat_cnt !== 3'((i + 1 > LOCK) ? LOCK : i + 1)) begin
            n_err++;
            $display("FAIL wstream_beatcnt beat %0d: got %0d want %0d", i, dut.u_grant.beat_cnt, (i + 1 > LOCK) ? LOCK : i + 1);
         end
      end
      drive(1'b1, rand_in(4096), 1'b1, rand_in(4096), rand_data(), '1);
      n_cmp++;
      if ({RAddrReady, WAddrReady} !== 2'b10) begin
         n_err++;
         $display("FAIL wstream_handover: got rd %b wr %b want 1 0", RAddrReady, WAddrReady);
      end
      tick();
      n_cmp++;
      if (RData !== exp_rdata || WResp !== 1'b0) begin
         n_err++;
         $display("FAIL wstream_read_data: got %h wresp %b want %h 0", RData, WResp, exp_rdata);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
   endtask

   task automatic test_out_of_range();
      drive(1'b1, 32'h0001_0000, 1'b0, 32'h0, '0, '0);
      n_cmp++;
      if (RAddrReady !== 1'b1 || MemCs !== 1'b0) begin
         n_err++;
         $display("FAIL oor_read_req: got rdy %b cs %b want 1 0", RAddrReady, MemCs);
      end
      tick();
      n_cmp++;
      if (RResp !== 1'b1 || RData !== '0) begin
         n_err++;
         $display("FAIL oor_read_resp: got resp %b data %h want 1 0", RResp, RData);
      end
      drive(1'b0, 32'h0, 1'b1, 32'hFFFF_0040, rand_data(), '1);
      n_cmp++;
      if (WAddrReady !== 1'b1 || MemCs !== 1'b0 || MemBe !== '0) begin
         n_err++;
         $display("FAIL oor_write_req: got rdy %b cs %b be %h want 1 0 0", WAddrReady, MemCs, MemBe);
      end
      tick();
      n_cmp++;
      if (WResp !== 1'b1 || RResp !== 1'b1) begin
         n_err++;
         $display("FAIL oor_write_resp: got wresp %b rresp %b want 1 1", WResp, RResp);
      end
      drive(1'b1, 32'h80, 1'b0, 32'h0, '0, '0);
      tick();
      n_cmp++;
      if (RResp !== 1'b0 || WResp !== 1'b1 || RData !== ref_mem[8]) begin
         n_err++;
         $display("FAIL oor_recover: got rresp %b wresp %b data %h want 0 1 %h", RResp, WResp, RData, ref_mem[8]);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
   endtask

   task automatic test_write_first();
      logic [DW-1:0] old_w;
      old_w = ref_mem[7];
      drive(1'b0, 32'h0, 1'b1, 32'h70, {16{8'hA5}}, 16'h00FF);
      n_cmp++;
      if (MemBe !== 16'h00FF || MemWe !== 1'b1 || MemAddr !== 12'd7) begin
         n_err++;
         $display("FAIL wf_write: got be %h we %b addr %0d want 00ff 1 7", MemBe, MemWe, MemAddr);
      end
      tick();
      drive(1'b1, 32'h70, 1'b0, 32'h0, '0, '0);
      tick();
      n_cmp++;
      if (RData !== {old_w[127:64], {8{8'hA5}}}) begin
         n_err++;
         $display("FAIL wf_readback: got %h want %h", RData, {old_w[127:64], {8{8'hA5}}});
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
   endtask

   task automatic test_reset_midburst();
      drive(1'b0, 32'h0, 1'b1, 32'h100, rand_data(), '1);
      tick();
      drive(1'b0, 32'h0, 1'b1, 32'h110, rand_data(), '1);
      tick();
      drive(1'b0, 32'h0, 1'b1, 32'h2000_0000, rand_data(), '1);
      tick();
      n_cmp++;
      if (dut.u_grant.beat_cnt !== 3'd3 || WResp !== 1'b1) begin
         n_err++;
         $display("FAIL midburst_setup: got cnt %0d wresp %b want 3 1", dut.u_grant.beat_cnt, WResp);
      end
      @(negedge ACLK);
      ARESETn = 1'b0;
      RAddrValid = 1'b1;
      RAddrOut = 32'h30;
      WAddrValid = 1'b1;
      WAddrOut = 32'h40;
      #1;
      n_cmp++;
      if ({RResp, WResp} !== 2'b00 || RData !== '0) begin
         n_err++;
         $display("FAIL midburst_reset_resp: got %b%b data %h want 00 0", RResp, WResp, RData);
      end
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if ({RAddrReady, WAddrReady} !== 2'b10) begin
         n_err++;
         $display("FAIL midburst_first_grant: got rd %b wr %b want 1 0", RAddrReady, WAddrReady);
      end
      g_exp = pick(1'b1, 1'b1);
      commit(g_exp, RAddrOut, WAddrOut, WData, WStrb);
      tick();
      n_cmp++;
      if (RData !== ref_mem[3] || {RResp, WResp} !== 2'b00) begin
         n_err++;
         $display("FAIL midburst_after: got %h %b%b want %h 00", RData, RResp, WResp, ref_mem[3]);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
   endtask

   task automatic test_random();
      logic rv, wv;
      logic [31:0] ra, wa;
      for (int i = 0; i < 120; i++) begin
         rv = $urandom_range(0, 3) != 0;
         wv = $urandom_range(0, 3) != 0;
         ra = $urandom_range(0, 7) == 0 ? {16'($urandom_range(1, 65535)), 16'($urandom)} : rand_in(16);
         wa = $urandom_range(0, 7) == 0 ? {16'($urandom_range(1, 65535)), 16'($urandom)} : rand_in(16);
         drive(rv, ra, wv, wa, rand_data(), 16'($urandom));
         n_cmp++;
         if ({RAddrReady, WAddrReady} !== {g_exp == 1, g_exp == 2} || MemCs !== exp_cs ||
             (exp_cs && MemAddr !== exp_word) || MemWe !== (exp_cs && g_exp == 2)) begin
            n_err++;
            $display("FAIL random_req %0d: got rd %b wr %b cs %b we %b addr %0d want g %0d cs %b addr %0d",
                     i, RAddrReady, WAddrReady, MemCs, MemWe, MemAddr, g_exp, exp_cs, exp_word);
         end
         tick();
         n_cmp++;
         if (RData !== exp_rdata || RResp !== exp_rresp || WResp !== exp_wresp) begin
            n_err++;
            $display("FAIL random_resp %0d: got %h %b %b want %h %b %b", i, RData, RResp, WResp, exp_rdata, exp_rresp, exp_wresp);
         end
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, '0, '0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         sram[i] <= init_word(i);
         ref_mem[i] = init_word(i);
      end
      model_reset();
      test_reset();
      test_single_read();
      test_contended();
      test_write_stream();
      test_out_of_range();
      test_write_first();
      test_reset_midburst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
